// File: rtl/prefix_sub_pipe_pkg.sv
// Shared definitions for the pipelined prefix subtractor: widths, opcodes and
// the generate/propagate combine cell used at every prefix node.
package prefix_sub_pipe_pkg;

    localparam int LEN_DATA_DEF = 64;
    localparam int TAG_W_DEF    = 4;
    localparam int LAT          = 4;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_RSB = 2'b01,
        OP_NEG = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    // Combine a high group (g_hi, p_hi) with the adjacent lower group (g_lo, p_lo).
    function automatic logic [1:0] gp_cell(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/prefix_sub_pipe_level.sv
// One Sklansky prefix level: bits in the upper half of each 2*SPAN block absorb
// the group ending just below that half; all other bits pass through.
module prefix_sub_level
    import prefix_sub_pipe_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF,
    parameter int LEVEL    = 1
) (
    input  logic [LEN_DATA-1:0] g_in,
    input  logic [LEN_DATA-1:0] p_in,
    output logic [LEN_DATA-1:0] g_out,
    output logic [LEN_DATA-1:0] p_out
);

    localparam int SPAN = 1 << (LEVEL - 1);

    genvar gi;
    generate
        for (gi = 0; gi < LEN_DATA; gi++) begin : g_bit
            if (((gi / SPAN) % 2) == 1) begin : g_node
                localparam int SRC = (gi / SPAN) * SPAN - 1;
                assign {g_out[gi], p_out[gi]} = gp_cell(g_in[gi], p_in[gi], g_in[SRC], p_in[SRC]);
            end else begin : g_pass
                assign g_out[gi] = g_in[gi];
                assign p_out[gi] = p_in[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/prefix_sub_pipe.sv
// Four-register subtract/compare pipeline (pre-process, two prefix halves,
// sum/flags) with a whole-pipe stall driven by the output handshake.
module prefix_sub_pipe
    import prefix_sub_pipe_pkg::*;
#(
    parameter int LEN_DATA = LEN_DATA_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] in_a,
    input  logic [LEN_DATA-1:0] in_b,
    input  logic [1:0]          in_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] out_res,
    output logic                out_borrow,
    output logic                out_zero,
    output logic                out_neg,
    output logic                out_ovf,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int LEVELS = $clog2(LEN_DATA);
    localparam int HALF   = LEVELS / 2;

    logic                adv;
    logic [LEN_DATA-1:0] sel_x, sel_y, pre_g, pre_p;

    logic                r1_valid, r2_valid, r3_valid;
    logic [LEN_DATA-1:0] r1_g, r1_p, r1_psum;
    logic [LEN_DATA-1:0] r2_g, r2_p, r2_psum;
    logic [LEN_DATA-1:0] r3_g, r3_psum;
    logic                r1_cmp, r2_cmp, r3_cmp;
    logic                r1_sx, r2_sx, r3_sx;
    logic                r1_sy, r2_sy, r3_sy;
    logic [TAG_W-1:0]    r1_tag, r2_tag, r3_tag;

    logic [LEN_DATA-1:0] lvl_g_in  [1:LEVELS];
    logic [LEN_DATA-1:0] lvl_p_in  [1:LEVELS];
    logic [LEN_DATA-1:0] lvl_g_out [1:LEVELS];
    logic [LEN_DATA-1:0] lvl_p_out [1:LEVELS];
    logic [LEN_DATA-1:0] sum_d;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        sel_x = in_a;
        sel_y = in_b;
        case (in_op)
            OP_RSB: begin
                sel_x = in_b;
                sel_y = in_a;
            end
            OP_NEG: begin
                sel_x = '0;
                sel_y = in_a;
            end
            default: ;
        endcase
    end

    assign pre_g = sel_x & ~sel_y;
    assign pre_p = sel_x ^ ~sel_y;

    // Levels 1..HALF read R1, the remaining levels read R2.
    genvar gi;
    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : g_level
            if (gi == 1) begin : g_src_r1
                assign lvl_g_in[gi] = r1_g;
                assign lvl_p_in[gi] = r1_p;
            end else if (gi == HALF + 1) begin : g_src_r2
                assign lvl_g_in[gi] = r2_g;
                assign lvl_p_in[gi] = r2_p;
            end else begin : g_src_chain
                assign lvl_g_in[gi] = lvl_g_out[gi-1];
                assign lvl_p_in[gi] = lvl_p_out[gi-1];
            end
            prefix_sub_level #(
                .LEN_DATA (LEN_DATA),
                .LEVEL    (gi)
            ) u_level (
                .g_in  (lvl_g_in[gi]),
                .p_in  (lvl_p_in[gi]),
                .g_out (lvl_g_out[gi]),
                .p_out (lvl_p_out[gi])
            );
        end
    endgenerate

    // Carry into bit i is the prefix generate of bit i-1; bit 0 sees the folded carry-in.
    assign sum_d = r3_psum ^ {r3_g[LEN_DATA-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0; r1_g <= '0; r1_p <= '0; r1_psum <= '0;
            r1_cmp <= 1'b0; r1_sx <= 1'b0; r1_sy <= 1'b0; r1_tag <= '0;
            r2_valid <= 1'b0; r2_g <= '0; r2_p <= '0; r2_psum <= '0;
            r2_cmp <= 1'b0; r2_sx <= 1'b0; r2_sy <= 1'b0; r2_tag <= '0;
            r3_valid <= 1'b0; r3_g <= '0; r3_psum <= '0;
            r3_cmp <= 1'b0; r3_sx <= 1'b0; r3_sy <= 1'b0; r3_tag <= '0;
            out_valid <= 1'b0; out_res <= '0; out_borrow <= 1'b0;
            out_zero <= 1'b0; out_neg <= 1'b0; out_ovf <= 1'b0; out_tag <= '0;
        end else if (adv) begin
            r1_valid <= in_valid;
            r1_g     <= {pre_g[LEN_DATA-1:1], pre_g[0] | pre_p[0]};
            r1_p     <= {pre_p[LEN_DATA-1:1], 1'b0};
            r1_psum  <= pre_p;
            r1_cmp   <= (in_op == OP_CMP);
            r1_sx    <= sel_x[LEN_DATA-1];
            r1_sy    <= sel_y[LEN_DATA-1];
            r1_tag   <= in_tag;

            r2_valid <= r1_valid;
            r2_g     <= lvl_g_out[HALF];
            r2_p     <= lvl_p_out[HALF];
            r2_psum  <= r1_psum;
            r2_cmp   <= r1_cmp;
            r2_sx    <= r1_sx;
            r2_sy    <= r1_sy;
            r2_tag   <= r1_tag;

            r3_valid <= r2_valid;
            r3_g     <= lvl_g_out[LEVELS];
            r3_psum  <= r2_psum;
            r3_cmp   <= r2_cmp;
            r3_sx    <= r2_sx;
            r3_sy    <= r2_sy;
            r3_tag   <= r2_tag;

            out_valid  <= r3_valid;
            out_res    <= r3_cmp ? '0 : sum_d;
            out_borrow <= ~r3_g[LEN_DATA-1];
            out_zero   <= (sum_d == '0);
            out_neg    <= sum_d[LEN_DATA-1];
            out_ovf    <= (r3_sx != r3_sy) && (sum_d[LEN_DATA-1] != r3_sx);
            out_tag    <= r3_tag;
        end
    end

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Directed and random checks of prefix_sub_pipe against a plain-arithmetic
// model of modular subtraction and its flags.
module tb_prefix_sub_pipe;
    import prefix_sub_pipe_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        borrow;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_a, in_b, out_res;
    logic [1:0]  in_op;
    logic [3:0]  in_tag, out_tag;
    logic        out_borrow, out_zero, out_neg, out_ovf;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pop_count = 0;
    exp_t exp_q[$];
    exp_t last_out;
    exp_t held;
    bit   stalled = 0;

    prefix_sub_pipe #(.LEN_DATA(64), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_borrow(out_borrow), .out_zero(out_zero),
        .out_neg(out_neg), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [3:0] tag);
        logic [63:0] x, y, d;
        logic [64:0] w;
        exp_t e;
        case (op)
            2'b01:   begin x = b;     y = a; end
            2'b10:   begin x = 64'd0; y = a; end
            default: begin x = a;     y = b; end
        endcase
        w = {1'b0, x} - {1'b0, y};
        d = w[63:0];
        e.res    = (op == 2'b11) ? 64'd0 : d;
        e.borrow = w[64];
        e.zero   = (d == 64'd0);
        e.neg    = d[63];
        e.ovf    = (x[63] != y[63]) && (d[63] != x[63]);
        e.tag    = tag;
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] res, input logic borrow, input logic zero,
                                input logic neg, input logic ovf, input logic [3:0] tag);
        exp_t e;
        e.res = res; e.borrow = borrow; e.zero = zero; e.neg = neg; e.ovf = ovf; e.tag = tag;
        return e;
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted beat is modelled, every popped result compared in order.
    always @(negedge clk) begin
        exp_t cur, e;
        cur = mk(out_res, out_borrow, out_zero, out_neg, out_ovf, out_tag);
        if (rst) begin
            stalled = 0;
        end else begin
            chk("in_ready", {127'd0, in_ready}, {127'd0, (!out_valid || out_ready)});
            if (stalled) chk("hold", {out_valid, cur}, {1'b1, held});
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop: unexpected result tag=%h res=%h, required none", out_tag, out_res);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", cur, e);
                end
                last_out = cur;
                pop_count++;
            end
            stalled = out_valid && !out_ready;
            held    = cur;
        end
    end

    task automatic drive_beat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] tag);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept", {127'd0, ok}, 128'd1);
    endtask

    // Latency counts cycles from the one where the beat is presented and accepted
    // to the first one where out_valid is seen.
    task automatic send_check(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] tag, input exp_t lit, input bit chk_lat);
        int pc0, cnt;
        chk("model_pin", model(op, a, b, tag), lit);
        pc0 = pop_count;
        drive_beat(op, a, b, tag);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (chk_lat) chk("latency", 128'(cnt), 128'd4);
        for (int i = 0; i < 20 && pop_count == pc0; i++) @(posedge clk);
        #1;
        chk("direct", last_out, lit);
    endtask

    initial begin
        int pc0, sent, acc, seen;
        logic [3:0] pat;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, out_res, out_borrow, out_zero, out_neg, out_ovf, out_tag}, '0);
        chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_check(2'b00, 64'd5, 64'd3, 4'h5, mk(64'd2, 0, 0, 0, 0, 4'h5), 1);
        send_check(2'b00, 64'd3, 64'd5, 4'h1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0, 4'h1), 0);
        send_check(2'b01, 64'd3, 64'd5, 4'h2, mk(64'd2, 0, 0, 0, 0, 4'h2), 0);
        send_check(2'b00, 64'h8000_0000_0000_0000, 64'd1, 4'h3,
                   mk(64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 4'h3), 0);
        send_check(2'b10, 64'h8000_0000_0000_0000, 64'd0, 4'h4,
                   mk(64'h8000_0000_0000_0000, 1, 0, 1, 1, 4'h4), 0);
        send_check(2'b11, 64'h1234, 64'h1234, 4'h6, mk(64'd0, 0, 1, 0, 0, 4'h6), 0);
        send_check(2'b11, 64'd0, 64'd1, 4'h7, mk(64'd0, 1, 0, 1, 0, 4'h7), 0);

        // Streaming with out_ready pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        sent = 0;
        pc0 = pop_count;
        for (int c = 0; c < 200 && (sent < 8 || pop_count < pc0 + 8); c++) begin
            out_ready = pat[3 - (c % 4)];
            in_valid  = (sent < 8);
            in_op     = 2'b00;
            in_a      = 64'(sent * 3 + 1);
            in_b      = 64'(sent);
            in_tag    = 4'(sent);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_pops", 128'(pop_count - pc0), 128'd8);
        chk("stream_drained", 128'(exp_q.size()), 128'd0);

        // Reset with three beats in flight.
        drive_beat(2'b00, 64'd10, 64'd1, 4'h8);
        drive_beat(2'b01, 64'd10, 64'd2, 4'h9);
        drive_beat(2'b10, 64'd10, 64'd3, 4'hA);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("post_reset_quiet", 128'(seen), 128'd0);
        send_check(2'b00, 64'd100, 64'd58, 4'hB, mk(64'd42, 0, 0, 0, 0, 4'hB), 1);

        // Random operands and ops with random backpressure.
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = rand_opnd();
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : rand_opnd();
            in_tag    = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("random_accepted", 128'(acc), 128'd10000);
        chk("random_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
